// File: rtl/syn_harness_seq_pkg.sv
// Shared types and constants for the synthesis-harness sequencer.
// State encodings, default widths and the counter-width helper.
package syn_harness_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_LOAD    = 2'd1,
      ST_RUN     = 2'd2,
      ST_CAPTURE = 2'd3
   } state_t;

   localparam int DEF_IN_WIDTH       = 256;
   localparam int DEF_TIMEOUT_CYCLES = 65536;

   // Counter must hold the larger of the shift length and the watchdog limit.
   function automatic int cnt_width(input int in_width, input int timeout_cycles);
      int m;
      m = (in_width > timeout_cycles) ? in_width : timeout_cycles;
      return $clog2(m + 1);
   endfunction

endpackage

// File: rtl/syn_harness_counter.sv
// Up-counter with async reset, synchronous clear, enable and a
// terminal-count compare. Shared by the LOAD shift count and the RUN watchdog.
module syn_harness_counter
   import syn_harness_seq_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             sclr,
   input  logic             en,
   input  logic [WIDTH-1:0] term,
   output logic [WIDTH-1:0] cnt,
   output logic             at_term
);

   // Synchronous clear has priority over counting.
   always_ff @(posedge clock or posedge clear) begin
      if (clear)
         cnt <= '0;
      else if (sclr)
         cnt <= '0;
      else if (en)
         cnt <= cnt + 1'b1;
   end

   assign at_term = (cnt == term);

endmodule

// File: rtl/syn_harness_seq.sv
// Sequencer for the FPGA synthesis harness: shifts IN_WIDTH bits into the
// input harness, pulses the core start, waits for done, then enables one
// capture into the output harness.
// Optional RUN-state watchdog: define SYN_HARNESS_TIMEOUT_EN.
module syn_harness_seq
   import syn_harness_seq_pkg::*;
#(
   parameter int IN_WIDTH       = DEF_IN_WIDTH,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic clock,
   input  logic clear,
   input  logic start,
   output logic shift_en,
   output logic dut_start,
   input  logic dut_done,
   output logic capture_en,
   output logic busy,
   output logic done,
   output logic timeout
);

   localparam int CNT_WIDTH = cnt_width(IN_WIDTH, TIMEOUT_CYCLES);
   localparam logic [CNT_WIDTH-1:0] LOAD_LAST = CNT_WIDTH'(IN_WIDTH - 1);

   state_t               state_q, state_d;
   logic                 start_q;
   logic                 accept;
   logic                 first_run;
   logic                 cnt_en;
   logic                 cnt_sclr;
   logic                 at_term;
   logic [CNT_WIDTH-1:0] cnt;
   logic [CNT_WIDTH-1:0] term;
   logic                 done_q;

   assign accept    = start & ~start_q & (state_q == ST_IDLE);
   // The counter is zero only on the first RUN cycle, which marks the start pulse.
   assign first_run = (state_q == ST_RUN) && (cnt == '0);
   // Any state change restarts the count from zero for the new state.
   assign cnt_sclr  = (state_d != state_q);

`ifdef SYN_HARNESS_TIMEOUT_EN
   localparam logic [CNT_WIDTH-1:0] RUN_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   assign term = (state_q == ST_RUN) ? RUN_LAST : LOAD_LAST;
`else
   assign term = LOAD_LAST;
`endif

   syn_harness_counter #(.WIDTH(CNT_WIDTH)) u_cnt (
      .clock   (clock),
      .clear   (clear),
      .sclr    (cnt_sclr),
      .en      (cnt_en),
      .term    (term),
      .cnt     (cnt),
      .at_term (at_term)
   );

   // State register, start edge history and sticky completion flag.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= ST_IDLE;
         start_q <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         start_q <= start;
         if (accept)
            done_q <= 1'b0;
         else if (state_q == ST_CAPTURE)
            done_q <= 1'b1;
      end
   end

   // Next-state and counter enable; done is ignored on the first RUN cycle.
   always_comb begin
      state_d = state_q;
      cnt_en  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept)
               state_d = ST_LOAD;
         end
         ST_LOAD: begin
            cnt_en = 1'b1;
            if (at_term)
               state_d = ST_RUN;
         end
         ST_RUN: begin
`ifdef SYN_HARNESS_TIMEOUT_EN
            cnt_en = 1'b1;
            if (!first_run && dut_done)
               state_d = ST_CAPTURE;
            else if (at_term)
               state_d = ST_IDLE;
`else
            // Step off zero once so the start pulse is a single cycle.
            cnt_en = first_run;
            if (!first_run && dut_done)
               state_d = ST_CAPTURE;
`endif
         end
         ST_CAPTURE: state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

`ifdef SYN_HARNESS_TIMEOUT_EN
   logic timeout_q;

   // Sticky watchdog flag: set when RUN expires without done, cleared on accept.
   always_ff @(posedge clock or posedge clear) begin
      if (clear)
         timeout_q <= 1'b0;
      else if (accept)
         timeout_q <= 1'b0;
      else if (state_q == ST_RUN && state_d == ST_IDLE)
         timeout_q <= 1'b1;
   end

   assign timeout = timeout_q;
`else
   assign timeout = 1'b0;
`endif

   assign shift_en   = (state_q == ST_LOAD);
   assign dut_start  = first_run;
   assign capture_en = (state_q == ST_CAPTURE);
   assign busy       = (state_q != ST_IDLE);
   assign done       = done_q;

endmodule
